// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and data access.
// Data wins by default; fetch is forced through after MAX_DMEM_BURST data grants while it waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DMEM_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,

  input  logic                dmem_req,
  input  logic                dmem_write,
  input  logic [DATA_W/8-1:0] dmem_wmask,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,

  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_DMEM_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DMEM_BURST);

  arb_state_t       state;
  logic [CNT_W-1:0] burst_cnt;

  logic fetch_starved;
  logic grant_d;
  logic grant_i;

  // Only meaningful in IDLE; the FSM ignores them in the busy states.
  assign fetch_starved = imem_req && (burst_cnt == CNT_MAX);
  assign grant_d       = dmem_req && !fetch_starved;
  assign grant_i       = imem_req && !grant_d;

  // Completion is routed straight from the memory so the CPU stall releases in the same cycle.
  assign imem_resp  = (state == I_BUSY) && mem_resp;
  assign dmem_resp  = (state == D_BUSY) && mem_resp;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_BUSY;
            mem_addr  <= dmem_addr;
            mem_wdata <= dmem_wdata;
            mem_wmask <= dmem_write ? dmem_wmask : MASK_W'(0);
            mem_write <= dmem_write;
            mem_read  <= !dmem_write;
            // Count only data grants that made a waiting fetch wait longer.
            if (imem_req) begin
              burst_cnt <= (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
            end else begin
              burst_cnt <= '0;
            end
          end else if (grant_i) begin
            state     <= I_BUSY;
            mem_addr  <= imem_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= '0;
          end
        end

        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam int MAX_B  = 4;
  localparam logic [31:0] IA = 32'h6000_0000;
  localparam logic [31:0] DA = 32'h0000_0100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req = 1'b0;
  logic [ADDR_W-1:0] imem_addr = '0;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_resp;
  logic              dmem_req = 1'b0;
  logic              dmem_write = 1'b0;
  logic [MASK_W-1:0] dmem_wmask = '0;
  logic [ADDR_W-1:0] dmem_addr = '0;
  logic [DATA_W-1:0] dmem_wdata = '0;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DMEM_BURST(MAX_B)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          wr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } rsp_t;

  txn_t        grant_q[$];
  rsp_t        resp_q[$];
  logic [31:0] obs_log[$];

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level)
  bit m_busy    = 1'b0;
  bit m_owner_d = 1'b0;
  int m_cnt     = 0;
  int lat_left  = 0;
  bit i_done    = 1'b0;
  bit d_done    = 1'b0;

  // Stimulus knobs
  bit          auto_mode = 1'b0;
  bit          hold_reqs = 1'b0;
  bit          stray_en  = 1'b0;
  int          p_i = 0;
  int          p_d = 0;
  int          lat_max = 3;
  int          next_lat = -1;
  bit          fix_rdata = 1'b0;
  logic [31:0] fixed_rdata = '0;

  bit   mon_en = 1'b0;
  bit   mon_in_txn = 1'b0;
  txn_t mon_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model from pre-edge inputs, then drive memory and requesters.
  task automatic step();
    txn_t t;
    bit   starve;
    @(posedge clk);
    i_done = 1'b0;
    d_done = 1'b0;
    if (rst) begin
      m_busy   = 1'b0;
      m_cnt    = 0;
      lat_left = 0;
    end else if (m_busy) begin
      if (mem_resp) begin
        m_busy = 1'b0;
        if (m_owner_d) d_done = 1'b1;
        else           i_done = 1'b1;
      end
    end else begin
      starve = imem_req && (m_cnt >= MAX_B);
      if (dmem_req && !starve) begin
        t.is_d  = 1'b1;
        t.addr  = dmem_addr;
        t.wr    = dmem_write;
        t.wmask = dmem_write ? dmem_wmask : 4'h0;
        t.wdata = dmem_wdata;
        grant_q.push_back(t);
        m_cnt     = imem_req ? ((m_cnt < MAX_B) ? m_cnt + 1 : MAX_B) : 0;
        m_busy    = 1'b1;
        m_owner_d = 1'b1;
      end else if (imem_req) begin
        t.is_d  = 1'b0;
        t.addr  = imem_addr;
        t.wr    = 1'b0;
        t.wmask = 4'h0;
        t.wdata = '0;
        grant_q.push_back(t);
        m_cnt     = 0;
        m_busy    = 1'b1;
        m_owner_d = 1'b0;
      end else begin
        m_cnt = 0;
      end
      if (m_busy) lat_left = (next_lat >= 0) ? next_lat : int'($urandom_range(lat_max, 0));
    end

    #1;
    if (m_busy) begin
      if (lat_left == 0) begin
        rsp_t r;
        mem_resp  = 1'b1;
        mem_rdata = fix_rdata ? fixed_rdata : $urandom;
        r.is_d  = m_owner_d;
        r.rdata = mem_rdata;
        resp_q.push_back(r);
      end else begin
        lat_left--;
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      mem_resp  = stray_en && ($urandom_range(99, 0) < 30);
      mem_rdata = $urandom;
    end

    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end else begin
      if (i_done && !hold_reqs) imem_req = 1'b0;
      if (d_done && !hold_reqs) dmem_req = 1'b0;
      if (auto_mode) begin
        if (!imem_req && $urandom_range(99, 0) < p_i) begin
          imem_req  = 1'b1;
          imem_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!dmem_req && $urandom_range(99, 0) < p_d) begin
          dmem_req   = 1'b1;
          dmem_addr  = $urandom & 32'hFFFF_FFFC;
          dmem_write = $urandom_range(1, 0) == 1;
          dmem_wmask = 4'($urandom);
          dmem_wdata = $urandom;
        end
      end
    end
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a response.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("resp_exclusive", 32'(imem_resp & dmem_resp), 32'd0);
      if (resp_q.size() > 0) begin
        rsp_t r;
        r = resp_q.pop_front();
        chk("resp_owner", {30'd0, imem_resp, dmem_resp}, r.is_d ? 32'd1 : 32'd2);
        if (r.is_d && dmem_resp)  chk("dmem_rdata", dmem_rdata, r.rdata);
        if (!r.is_d && imem_resp) chk("imem_rdata", imem_rdata, r.rdata);
      end else begin
        chk("spurious_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
      end

      chk("strobe_active", 32'(mem_read | mem_write), 32'(m_busy));
      if ((mem_read || mem_write) && !mon_in_txn) begin
        mon_in_txn = 1'b1;
        obs_log.push_back(mem_addr);
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", 32'(mem_read | mem_write), 32'd0);
        end else begin
          mon_cur = grant_q.pop_front();
          chk("grant_addr",  mem_addr, mon_cur.addr);
          chk("grant_read",  32'(mem_read), 32'(!mon_cur.wr));
          chk("grant_write", 32'(mem_write), 32'(mon_cur.wr));
          chk("grant_wmask", 32'(mem_wmask), 32'(mon_cur.wmask));
          if (mon_cur.wr) chk("grant_wdata", mem_wdata, mon_cur.wdata);
        end
      end else if (mon_in_txn) begin
        chk("hold_addr",  mem_addr, mon_cur.addr);
        chk("hold_write", 32'(mem_write), 32'(mon_cur.wr));
      end
      if (mem_resp || rst) mon_in_txn = 1'b0;
    end
  end

  initial begin
    int wr_cyc, rd_cyc, dresp_cnt, quiet_cnt;

    repeat (3) step();
    rst = 1'b0;
    chk("rst_mem_read",  32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_state",     32'(dut.state), 32'(IDLE));
    chk("rst_burst_cnt", 32'(dut.burst_cnt), 32'd0);
    chk("rst_resp",      {30'd0, imem_resp, dmem_resp}, 32'd0);
    mon_en = 1'b1;

    // Single fetch answered in the first busy cycle
    next_lat = 0; fix_rdata = 1'b1; fixed_rdata = 32'h0000_0013;
    imem_addr = IA; imem_req = 1'b1;
    step();
    chk("t1_mem_read",   32'(mem_read), 32'd1);
    chk("t1_mem_addr",   mem_addr, IA);
    chk("t1_imem_resp",  32'(imem_resp), 32'd1);
    chk("t1_imem_rdata", imem_rdata, 32'h0000_0013);
    step();
    chk("t1_read_drop",  32'(mem_read), 32'd0);
    fix_rdata = 1'b0;

    // Store against a 3-cycle memory
    next_lat = 2;
    dmem_addr = DA; dmem_write = 1'b1; dmem_wmask = 4'b0011; dmem_wdata = 32'hDEAD_BEEF;
    dmem_req = 1'b1;
    wr_cyc = 0; rd_cyc = 0; dresp_cnt = 0;
    repeat (6) begin
      step();
      if (mem_write) begin
        wr_cyc++;
        chk("t2_wmask", 32'(mem_wmask), 32'h3);
      end
      if (mem_read)  rd_cyc++;
      if (dmem_resp) dresp_cnt++;
    end
    chk("t2_write_cycles", 32'(wr_cyc), 32'd3);
    chk("t2_read_cycles",  32'(rd_cyc), 32'd0);
    chk("t2_dmem_resps",   32'(dresp_cnt), 32'd1);

    // Simultaneous requests: data first, fetch after the idle gap
    next_lat = 1;
    obs_log.delete();
    imem_addr = IA; imem_req = 1'b1;
    dmem_addr = 32'h200; dmem_write = 1'b0; dmem_wmask = 4'hF; dmem_req = 1'b1;
    repeat (12) step();
    chk("t3_grants", 32'(obs_log.size()), 32'd2);
    if (obs_log.size() == 2) begin
      chk("t3_first",  obs_log[0], 32'h200);
      chk("t3_second", obs_log[1], IA);
    end

    // Starvation bound with both requests held
    next_lat = 0; hold_reqs = 1'b1;
    obs_log.delete();
    imem_addr = IA; imem_req = 1'b1;
    dmem_addr = DA; dmem_write = 1'b0; dmem_req = 1'b1;
    repeat (7) step();
    chk("t4_burst_cnt_full", 32'(dut.burst_cnt), 32'd4);
    repeat (4) step();
    hold_reqs = 1'b0; imem_req = 1'b0; dmem_req = 1'b0;
    repeat (3) step();
    chk("t4_grants", 32'(obs_log.size()), 32'd6);
    if (obs_log.size() == 6) begin
      chk("t4_g0", obs_log[0], DA);
      chk("t4_g1", obs_log[1], DA);
      chk("t4_g2", obs_log[2], DA);
      chk("t4_g3", obs_log[3], DA);
      chk("t4_g4", obs_log[4], IA);
      chk("t4_g5", obs_log[5], DA);
    end

    // Idle with stray memory responses
    stray_en = 1'b1; quiet_cnt = 0;
    repeat (10) begin
      step();
      if (mem_read || mem_write || imem_resp || dmem_resp) quiet_cnt++;
    end
    chk("t6_quiet_cycles", 32'(quiet_cnt), 32'd0);
    chk("t6_burst_cnt",    32'(dut.burst_cnt), 32'd0);
    stray_en = 1'b0;

    // Reset in the middle of a store
    next_lat = 10;
    dmem_addr = 32'h300; dmem_write = 1'b1; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
    dmem_req = 1'b1;
    step(); step();
    chk("t5_busy_write", 32'(mem_write), 32'd1);
    chk("t5_busy_state", 32'(dut.state), 32'(D_BUSY));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_write_cleared", 32'(mem_write), 32'd0);
    chk("t5_state_idle",    32'(dut.state), 32'(IDLE));
    chk("t5_addr_cleared",  mem_addr, 32'd0);
    stray_en = 1'b1; dresp_cnt = 0;
    repeat (8) begin
      step();
      if (dmem_resp || imem_resp) dresp_cnt++;
    end
    chk("t5_no_resp", 32'(dresp_cnt), 32'd0);

    // Randomized traffic
    next_lat = -1; lat_max = 3; p_i = 35; p_d = 45; auto_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if ((n % 16) == 0) chk("rand_burst_cnt", 32'(dut.burst_cnt), 32'(m_cnt));
    end
    auto_mode = 1'b0; stray_en = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (!m_busy && !imem_req && !dmem_req) break;
      step();
    end
    step(); step();
    chk("drain_grant_q", 32'(grant_q.size()), 32'd0);
    chk("drain_resp_q",  32'(resp_q.size()), 32'd0);
    chk("drain_idle",    32'(mem_read | mem_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
